// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
//
// Writeback stage of the pipeline and owner of the architectural integer
// register file (x0..x31). It takes the registered MEM/WB fields and selects
// the result, applying load extension where needed. It commits that result on
// the rising clock edge. It also serves the two decode read ports, which bypass
// the value being written this cycle, and exports the writeback value so EX
// can forward it.
//
// Optional build macro:
//   WB_INSTRET_EN  adds a 64-bit retired-instruction counter on port instret
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   wbValid    in   MEM/WB slot holds a real instruction (0 = bubble)
//   regWrtw    in   instruction writes rd
//   rsltSrcw   in   result select: 00 ALU, 01 load, 10 pc+4, 11 reserved
//   readDw     in   raw data-memory read word
//   pc4w       in   PC+4 of the instruction
//   ujWrtBckw  in   ALU / LUI / AUIPC result
//   rdw        in   destination register index
//   ldFn3w     in   load funct3 (LB/LH/LW/LBU/LHU)
//   ldOffw     in   byte offset of the load address
//   rs1d/rs2d  in   decode read indices
//   rd1d/rd2d  out  decode read data (combinational, with write-through)
//   fwdEnw     out  writeback forwarding valid (equals the write enable)
//   fwdRdw     out  writeback forwarding destination
//   fwdDataw   out  writeback forwarding data (valid regardless of fwdEnw)
//   instret    out  retired-instruction count (WB_INSTRET_EN only)
// ----------------------------------------------------------------------------
module wb_regfile #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   localparam int unsigned RegAw = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wbValid,
   input  logic             regWrtw,
   input  logic [1:0]       rsltSrcw,
   input  logic [XLEN-1:0]  readDw,
   input  logic [XLEN-1:0]  pc4w,
   input  logic [XLEN-1:0]  ujWrtBckw,
   input  logic [RegAw-1:0] rdw,
   input  logic [2:0]       ldFn3w,
   input  logic [1:0]       ldOffw,
   input  logic [RegAw-1:0] rs1d,
   input  logic [RegAw-1:0] rs2d,
   output logic [XLEN-1:0]  rd1d,
   output logic [XLEN-1:0]  rd2d,
   output logic             fwdEnw,
   output logic [RegAw-1:0] fwdRdw,
   output logic [XLEN-1:0]  fwdDataw
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]      instret
`endif
);

   localparam logic [1:0] SrcAlu  = 2'b00;
   localparam logic [1:0] SrcLoad = 2'b01;
   localparam logic [1:0] SrcPc4  = 2'b10;

   localparam logic [2:0] FnLb  = 3'b000;
   localparam logic [2:0] FnLh  = 3'b001;
   localparam logic [2:0] FnLw  = 3'b010;
   localparam logic [2:0] FnLbu = 3'b100;
   localparam logic [2:0] FnLhu = 3'b101;

   logic            we;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] result;

   // Entry 0 is never written; reads of x0 are forced to zero below.
   logic [XLEN-1:0] regs_q [NREG];

   // ---------------------------------------------------------------------
   // Load lane selection and extension
   // ---------------------------------------------------------------------
   always_comb begin
      ld_byte = readDw[7:0];
      unique case (ldOffw)
         2'd0: ld_byte = readDw[7:0];
         2'd1: ld_byte = readDw[15:8];
         2'd2: ld_byte = readDw[23:16];
         2'd3: ld_byte = readDw[31:24];
         default: ld_byte = readDw[7:0];
      endcase
   end

   // A misaligned halfword offset only looks at ldOffw[1]; alignment traps
   // are raised upstream, not here.
   assign ld_half = ldOffw[1] ? readDw[31:16] : readDw[15:0];

   always_comb begin
      load_data = '0;
      case (ldFn3w)
         FnLb:    load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         FnLh:    load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         FnLw:    load_data = readDw;
         FnLbu:   load_data = {{(XLEN-8){1'b0}}, ld_byte};
         FnLhu:   load_data = {{(XLEN-16){1'b0}}, ld_half};
         // Undefined funct3 still commits, with a zero result.
         default: load_data = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Result select and write enable
   // ---------------------------------------------------------------------
   always_comb begin
      result = '0;
      case (rsltSrcw)
         SrcAlu:  result = ujWrtBckw;
         SrcLoad: result = load_data;
         SrcPc4:  result = pc4w;
         default: result = '0;
      endcase
   end

   // x0 writes and the reserved select are dropped here. This makes forwarding
   // never advertise them.
   assign we = wbValid & regWrtw & (rdw != '0) & (rsltSrcw != 2'b11);

   assign fwdEnw   = we;
   assign fwdRdw   = rdw;
   assign fwdDataw = result;

   // ---------------------------------------------------------------------
   // Architectural register file
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 1; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < NREG; i++) begin
            if (we && (rdw == RegAw'(i))) begin
               regs_q[i] <= result;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Decode read ports with same-cycle write-through
   // ---------------------------------------------------------------------
   // While rst is high the bypass path must not leak a pending result.
   always_comb begin
      rd1d = '0;
      if (!rst && (rs1d != '0)) begin
         if (we && (rs1d == rdw)) begin
            rd1d = result;
         end else begin
            rd1d = regs_q[rs1d];
         end
      end
   end

   always_comb begin
      rd2d = '0;
      if (!rst && (rs2d != '0)) begin
         if (we && (rs2d == rdw)) begin
            rd2d = result;
         end else begin
            rd2d = regs_q[rs2d];
         end
      end
   end

`ifdef WB_INSTRET_EN
   // ---------------------------------------------------------------------
   // Retired-instruction counter: counts every valid slot, writing or not
   // ---------------------------------------------------------------------
   logic [63:0] instret_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_q <= '0;
      end else if (wbValid) begin
         instret_q <= instret_q + 64'd1;
      end
   end

   assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// ----------------------------------------------------------------------------
// tb_wb_regfile
//
// Self-checking bench for wb_regfile. Each scenario task drives the MEM/WB
// inputs, pushes the values it expects onto a scoreboard queue, and pops and
// compares them once the DUT output is stable.
// ----------------------------------------------------------------------------
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        wbValid;
   logic        regWrtw;
   logic [1:0]  rsltSrcw;
   logic [31:0] readDw;
   logic [31:0] pc4w;
   logic [31:0] ujWrtBckw;
   logic [4:0]  rdw;
   logic [2:0]  ldFn3w;
   logic [1:0]  ldOffw;
   logic [4:0]  rs1d;
   logic [4:0]  rs2d;
   logic [31:0] rd1d;
   logic [31:0] rd2d;
   logic        fwdEnw;
   logic [4:0]  fwdRdw;
   logic [31:0] fwdDataw;
`ifdef WB_INSTRET_EN
   logic [63:0] instret;
`endif

   wb_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .wbValid   (wbValid),
      .regWrtw   (regWrtw),
      .rsltSrcw  (rsltSrcw),
      .readDw    (readDw),
      .pc4w      (pc4w),
      .ujWrtBckw (ujWrtBckw),
      .rdw       (rdw),
      .ldFn3w    (ldFn3w),
      .ldOffw    (ldOffw),
      .rs1d      (rs1d),
      .rs2d      (rs2d),
      .rd1d      (rd1d),
      .rd2d      (rd2d),
      .fwdEnw    (fwdEnw),
      .fwdRdw    (fwdRdw),
      .fwdDataw  (fwdDataw)
`ifdef WB_INSTRET_EN
      ,
      .instret   (instret)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [63:0] val;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] model [32];

   task automatic push(input string n, input logic [63:0] v);
      exp_t x;
      x.name = n;
      x.val  = v;
      sb.push_back(x);
   endtask

   task automatic idle();
      wbValid   = 1'b0;
      regWrtw   = 1'b0;
      rsltSrcw  = 2'b00;
      readDw    = '0;
      pc4w      = '0;
      ujWrtBckw = '0;
      rdw       = '0;
      ldFn3w    = 3'b010;
      ldOffw    = 2'b00;
   endtask

   task automatic drive_wb(input logic v, input logic w, input logic [1:0] src,
                           input logic [4:0] rd, input logic [31:0] uj,
                           input logic [31:0] pc4, input logic [31:0] rdata,
                           input logic [2:0] fn3, input logic [1:0] off);
      wbValid   = v;
      regWrtw   = w;
      rsltSrcw  = src;
      rdw       = rd;
      ujWrtBckw = uj;
      pc4w      = pc4;
      readDw    = rdata;
      ldFn3w    = fn3;
      ldOffw    = off;
   endtask

   // Independent reference for the result path, written with shifts.
   function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [31:0] uj,
                                              input logic [31:0] pc4, input logic [31:0] rdata,
                                              input logic [2:0] fn3, input logic [1:0] off);
      logic [31:0] b;
      logic [31:0] h;
      b = (rdata >> (8 * int'(off))) & 32'hFF;
      h = (rdata >> (16 * int'(off[1]))) & 32'hFFFF;
      if (src == 2'b00) return uj;
      if (src == 2'b10) return pc4;
      if (src == 2'b11) return 32'h0;
      case (fn3)
         3'b000:  return (b[7]  ? (b | 32'hFFFF_FF00) : b);
         3'b001:  return (h[15] ? (h | 32'hFFFF_0000) : h);
         3'b010:  return rdata;
         3'b100:  return b;
         3'b101:  return h;
         default: return 32'h0;
      endcase
   endfunction

   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      idle();
      rs1d = 5'd5;
      rs2d = 5'd31;
      repeat (2) @(posedge clk);
      @(negedge clk);
      push("reset_rd1", 64'h0);
      push("reset_rd2", 64'h0);
      e = sb.pop_front(); checks++;
      if ({32'h0, rd1d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd1d, e.val);
      end
      e = sb.pop_front(); checks++;
      if ({32'h0, rd2d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd2d, e.val);
      end
      rst = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      for (int i = 0; i < 32; i++) begin
         rs1d = 5'(i);
         rs2d = 5'(31 - i);
         #1;
         push("reset_all_rd1", 64'h0);
         push("reset_all_rd2", 64'h0);
         e = sb.pop_front(); checks++;
         if ({32'h0, rd1d} !== e.val) begin
            errors++; $display("FAIL %s x%0d: got %h, expected %h", e.name, i, rd1d, e.val);
         end
         e = sb.pop_front(); checks++;
         if ({32'h0, rd2d} !== e.val) begin
            errors++; $display("FAIL %s x%0d: got %h, expected %h", e.name, 31 - i, rd2d, e.val);
         end
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_write_readback();
      @(negedge clk);
      drive_wb(1'b1, 1'b1, 2'b00, 5'd7, 32'hDEADBEEF, 32'h0, 32'h0, 3'b010, 2'b00);
      rs1d = 5'd1;
      #1;
      push("wr_fwd_en", 64'h1);
      push("wr_fwd_rd", 64'd7);
      push("wr_fwd_data", 64'hDEADBEEF);
      e = sb.pop_front(); checks++;
      if ({63'h0, fwdEnw} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, fwdEnw, e.val);
      end
      e = sb.pop_front(); checks++;
      if ({59'h0, fwdRdw} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, fwdRdw, e.val);
      end
      e = sb.pop_front(); checks++;
      if ({32'h0, fwdDataw} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, fwdDataw, e.val);
      end
      @(negedge clk);
      idle();
      model[7] = 32'hDEADBEEF;
      rs1d = 5'd7;
      #1;
      push("wr_readback", {32'h0, model[7]});
      e = sb.pop_front(); checks++;
      if ({32'h0, rd1d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd1d, e.val);
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_bypass();
      @(negedge clk);
      drive_wb(1'b1, 1'b1, 2'b00, 5'd9, 32'h5A5A_1234, 32'h0, 32'h0, 3'b010, 2'b00);
      rs1d = 5'd9;
      rs2d = 5'd9;
      #1;
      push("bypass_rd1", 64'h5A5A_1234);
      push("bypass_rd2", 64'h5A5A_1234);
      e = sb.pop_front(); checks++;
      if ({32'h0, rd1d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd1d, e.val);
      end
      e = sb.pop_front(); checks++;
      if ({32'h0, rd2d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd2d, e.val);
      end
      @(negedge clk);
      idle();
      model[9] = 32'h5A5A_1234;
      #1;
      push("bypass_stored", {32'h0, model[9]});
      e = sb.pop_front(); checks++;
      if ({32'h0, rd2d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd2d, e.val);
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_load_ext();
      logic [2:0]  fn  [11] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000,
                                3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
      logic [1:0]  off [11] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd1, 2'd0, 2'd2, 2'd0};
      logic [31:0] exp [11] = '{32'hFFFF_FF82, 32'h0000_0080, 32'hFFFF_80F1, 32'h0000_7F82,
                                32'h80F1_7F82, 32'h0000_007F, 32'hFFFF_80F1, 32'h80F1_7F82,
                                32'h0000_0000, 32'h0000_00F1, 32'h0000_0000};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive_wb(1'b1, 1'b1, 2'b01, 5'(10 + i), 32'h1111_1111, 32'h2222_2222,
                  32'h80F1_7F82, fn[i], off[i]);
         #1;
         push("load_fwd_en", 64'h1);
         push("load_fwd_data", {32'h0, exp[i]});
         e = sb.pop_front(); checks++;
         if ({63'h0, fwdEnw} !== e.val) begin
            errors++; $display("FAIL %s case %0d: got %h, expected %h", e.name, i, fwdEnw, e.val);
         end
         e = sb.pop_front(); checks++;
         if ({32'h0, fwdDataw} !== e.val) begin
            errors++; $display("FAIL %s case %0d: got %h, expected %h", e.name, i, fwdDataw, e.val);
         end
         model[10 + i] = exp[i];
      end
      @(negedge clk);
      idle();
      for (int i = 0; i < 11; i++) begin
         rs2d = 5'(10 + i);
         #1;
         push("load_readback", {32'h0, model[10 + i]});
         e = sb.pop_front(); checks++;
         if ({32'h0, rd2d} !== e.val) begin
            errors++; $display("FAIL %s x%0d: got %h, expected %h", e.name, 10 + i, rd2d, e.val);
         end
      end
      // pc+4 select
      @(negedge clk);
      drive_wb(1'b1, 1'b1, 2'b10, 5'd22, 32'h3333_3333, 32'h0000_1004, 32'h0, 3'b010, 2'b00);
      #1;
      push("pc4_fwd_data", 64'h0000_1004);
      e = sb.pop_front(); checks++;
      if ({32'h0, fwdDataw} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, fwdDataw, e.val);
      end
      model[22] = 32'h0000_1004;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_suppress();
      logic        sv  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic        sw  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [1:0]  ss  [4] = '{2'b00, 2'b00, 2'b11, 2'b00};
      logic [4:0]  srd [4] = '{5'd0, 5'd25, 5'd25, 5'd25};
      @(negedge clk);
      drive_wb(1'b1, 1'b1, 2'b00, 5'd25, 32'h1111_2222, 32'h0, 32'h0, 3'b010, 2'b00);
      model[25] = 32'h1111_2222;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive_wb(sv[i], sw[i], ss[i], srd[i], 32'h0000_1234, 32'h0, 32'h0, 3'b010, 2'b00);
         rs1d = srd[i];
         #1;
         push("supp_fwd_en", 64'h0);
         push("supp_bypass", {32'h0, model[srd[i]]});
         e = sb.pop_front(); checks++;
         if ({63'h0, fwdEnw} !== e.val) begin
            errors++; $display("FAIL %s case %0d: got %h, expected %h", e.name, i, fwdEnw, e.val);
         end
         e = sb.pop_front(); checks++;
         if ({32'h0, rd1d} !== e.val) begin
            errors++; $display("FAIL %s case %0d: got %h, expected %h", e.name, i, rd1d, e.val);
         end
         @(negedge clk);
         idle();
         #1;
         push("supp_after", {32'h0, model[srd[i]]});
         e = sb.pop_front(); checks++;
         if ({32'h0, rd1d} !== e.val) begin
            errors++; $display("FAIL %s case %0d: got %h, expected %h", e.name, i, rd1d, e.val);
         end
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_back_to_back();
      logic [31:0] res;
      logic        wexp;
      logic [31:0] r1;
      logic [31:0] r2;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         drive_wb(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom(), $urandom(),
                  $urandom(), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         rs1d = ($urandom_range(0, 2) == 0) ? rdw : 5'($urandom_range(0, 31));
         rs2d = ($urandom_range(0, 2) == 0) ? rdw : 5'($urandom_range(0, 31));
         res  = ref_result(rsltSrcw, ujWrtBckw, pc4w, readDw, ldFn3w, ldOffw);
         wexp = wbValid && regWrtw && (rdw != 0) && (rsltSrcw != 2'b11);
         r1   = (rs1d == 0) ? 32'h0 : ((wexp && rs1d == rdw) ? res : model[rs1d]);
         r2   = (rs2d == 0) ? 32'h0 : ((wexp && rs2d == rdw) ? res : model[rs2d]);
         push("b2b_fwd_en", {63'h0, wexp});
         push("b2b_fwd_data", {32'h0, res});
         push("b2b_rd1", {32'h0, r1});
         push("b2b_rd2", {32'h0, r2});
         #1;
         e = sb.pop_front(); checks++;
         if ({63'h0, fwdEnw} !== e.val) begin
            errors++; $display("FAIL %s #%0d: got %h, expected %h", e.name, n, fwdEnw, e.val);
         end
         e = sb.pop_front(); checks++;
         if ({32'h0, fwdDataw} !== e.val) begin
            errors++; $display("FAIL %s #%0d: got %h, expected %h", e.name, n, fwdDataw, e.val);
         end
         e = sb.pop_front(); checks++;
         if ({32'h0, rd1d} !== e.val) begin
            errors++; $display("FAIL %s #%0d: got %h, expected %h", e.name, n, rd1d, e.val);
         end
         e = sb.pop_front(); checks++;
         if ({32'h0, rd2d} !== e.val) begin
            errors++; $display("FAIL %s #%0d: got %h, expected %h", e.name, n, rd2d, e.val);
         end
         if (wexp) model[rdw] = res;
      end
      @(negedge clk);
      idle();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset_mid();
      @(negedge clk);
      drive_wb(1'b1, 1'b1, 2'b00, 5'd3, 32'hCAFE_0003, 32'h0, 32'h0, 3'b010, 2'b00);
      @(negedge clk);
      drive_wb(1'b1, 1'b1, 2'b00, 5'd3, 32'h0BAD_F00D, 32'h0, 32'h0, 3'b010, 2'b00);
      rs1d = 5'd3;
      rs2d = 5'd7;
      #1;
      push("mid_pre_bypass", 64'h0BAD_F00D);
      e = sb.pop_front(); checks++;
      if ({32'h0, rd1d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd1d, e.val);
      end
      #1;
      rst = 1'b1;
      #1;
      push("mid_rst_rd1", 64'h0);
      push("mid_rst_rd2", 64'h0);
      e = sb.pop_front(); checks++;
      if ({32'h0, rd1d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd1d, e.val);
      end
      e = sb.pop_front(); checks++;
      if ({32'h0, rd2d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd2d, e.val);
      end
      @(negedge clk);
      idle();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      #1;
      push("mid_after_x3", 64'h0);
      push("mid_after_x7", 64'h0);
      e = sb.pop_front(); checks++;
      if ({32'h0, rd1d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd1d, e.val);
      end
      e = sb.pop_front(); checks++;
      if ({32'h0, rd2d} !== e.val) begin
         errors++; $display("FAIL %s: got %h, expected %h", e.name, rd2d, e.val);
      end
`ifdef WB_INSTRET_EN
      // Four retired slots: x0 write, non-writing, reserved select, real write.
      @(negedge clk);
      drive_wb(1'b1, 1'b1, 2'b00, 5'd0, 32'h1, 32'h0, 32'h0, 3'b010, 2'b00);
      @(negedge clk);
      drive_wb(1'b1, 1'b0, 2'b00, 5'd4, 32'h2, 32'h0, 32'h0, 3'b010, 2'b00);
      @(negedge clk);
      drive_wb(1'b1, 1'b1, 2'b11, 5'd4, 32'h3, 32'h0, 32'h0, 3'b010, 2'b00);
      @(negedge clk);
      drive_wb(1'b1, 1'b1, 2'b00, 5'd4, 32'h4, 32'h0, 32'h0, 3'b010, 2'b00);
      @(negedge clk);
      idle();
      @(negedge clk);
      push("instret_count", 64'd4);
      e = sb.pop_front(); checks++;
      if (instret !== e.val) begin
         errors++; $display("FAIL %s: got %0d, expected %0d", e.name, instret, e.val);
      end
      rst = 1'b1;
      #1;
      push("instret_reset", 64'd0);
      e = sb.pop_front(); checks++;
      if (instret !== e.val) begin
         errors++; $display("FAIL %s: got %0d, expected %0d", e.name, instret, e.val);
      end
      @(negedge clk);
      rst = 1'b0;
`endif
   endtask

   // ---------------------------------------------------------------------
   initial begin
      rst  = 1'b1;
      rs1d = '0;
      rs2d = '0;
      idle();
      test_reset();
      test_write_readback();
      test_bypass();
      test_load_ext();
      test_suppress();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
